// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one function unit among NREQ requesters.
// It grants one requester, pulses unit_start, then holds the grant until done or watchdog timeout.
module alu_rr_arbiter #(
    parameter int NREQ        = 8,
    parameter int IDW         = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            unit_done,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid,
    output logic            unit_start,
    output logic            busy,
    output logic            timeout_err
);

    localparam int            CW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IDW-1:0]  grant_id_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            timeout_err_nxt;

    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;

    // Circular search from ptr; the IDW-bit add wraps because NREQ == 2**IDW.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = ptr;
        cand       = ptr;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + IDW'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_nxt       = grant;
        grant_id_nxt    = grant_id;
        cnt_nxt         = cnt;
        timeout_err_nxt = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt    = NREQ'(1) << pick_id;
                    grant_id_nxt = pick_id;
                    state_nxt    = S_START;
                end
            end
            S_START: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
                // Done takes priority, so a coincident timeout raises no error.
                if (unit_done || (TIMEOUT_EN && cnt == CNT_LAST)) begin
                    grant_nxt       = '0;
                    ptr_nxt         = grant_id + IDW'(1);
                    state_nxt       = S_IDLE;
                    timeout_err_nxt = !unit_done;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    assign grant_valid = |grant;
    assign unit_start  = (state == S_START);
    assign busy        = (state != S_IDLE);

endmodule
